// File: rtl/audio_i2s_tx_if.sv
// Sample handshake and I2S link bundle for audio_i2s_tx.
interface audio_i2s_tx_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic                    sample_in_valid;
    logic                    sample_req;
    logic                    i2s_bclk;
    logic                    i2s_lrclk;
    logic                    i2s_sdata;
    logic                    underrun;
    logic                    overrun;

    modport master (
        output sample_in, sample_in_valid,
        input  sample_req, i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun
    );

    modport slave (
        input  sample_in, sample_in_valid,
        output sample_req, i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// Mono sample -> I2S transmitter with single-entry holding buffer and underrun/overrun flags.
// Build option AUDIO_I2S_TX_MUTE_ON_UNDERRUN_EN: underrun frames send zeros instead of repeating.
module audio_i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_HALF    = 16
) (
    input logic           clk,
    input logic           rst,
    audio_i2s_tx_if.slave bus
);
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int CW         = $clog2(FRAME_BITS);
    localparam int HW         = $clog2(BCLK_HALF);

    generate
        if (SAMPLE_WIDTH > SLOT_WIDTH - 1 || BCLK_HALF < 2) begin : g_param_check
            $fatal(1, "audio_i2s_tx: need SAMPLE_WIDTH <= SLOT_WIDTH-1 and BCLK_HALF >= 2");
        end
    endgenerate

    logic [HW-1:0]           half_cnt;
    logic                    bclk;
    logic [CW-1:0]           bit_cnt;
    logic                    lrclk;
    logic                    sdata;
    logic                    req;
    logic                    und;
    logic                    ovr;
    logic [SAMPLE_WIDTH-1:0] buf_data;
    logic                    buf_full;
    logic [SAMPLE_WIDTH-1:0] last_sample;

    logic                    half_wrap;
    logic                    fall;
    logic [CW-1:0]           bit_next;
    logic                    frame_start;
    logic [SAMPLE_WIDTH-1:0] underrun_word;
    logic [SAMPLE_WIDTH-1:0] load_word;
    logic [SAMPLE_WIDTH-1:0] word_next;
    logic                    lr_next;
    logic [CW-1:0]           pos_next;
    logic                    sdata_next;

    assign half_wrap   = (half_cnt == HW'(BCLK_HALF - 1));
    assign fall        = half_wrap && bclk;
    assign bit_next    = (bit_cnt == CW'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
    assign frame_start = fall && (bit_next == '0);

`ifdef AUDIO_I2S_TX_MUTE_ON_UNDERRUN_EN
    assign underrun_word = '0;
`else
    assign underrun_word = last_sample;
`endif

    // The buffer is sampled before this cycle's write, so a coincident valid waits a frame.
    assign load_word = buf_full ? buf_data : underrun_word;
    assign word_next = frame_start ? load_word : last_sample;
    assign lr_next   = (bit_next >= CW'(SLOT_WIDTH));
    assign pos_next  = lr_next ? bit_next - CW'(SLOT_WIDTH) : bit_next;

    // One-bit I2S delay: slot position 0 is idle, MSB follows at position 1.
    always_comb begin
        sdata_next = 1'b0;
        for (int i = 1; i <= SAMPLE_WIDTH; i++) begin
            if (pos_next == CW'(i)) begin
                sdata_next = word_next[SAMPLE_WIDTH-i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            half_cnt    <= '0;
            bclk        <= 1'b0;
            bit_cnt     <= CW'(FRAME_BITS - 1);
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            req         <= 1'b0;
            und         <= 1'b0;
            ovr         <= 1'b0;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            last_sample <= '0;
        end else begin
            half_cnt <= half_wrap ? '0 : half_cnt + 1'b1;
            if (half_wrap) begin
                bclk <= ~bclk;
            end

            req <= frame_start;
            und <= frame_start && !buf_full;
            ovr <= bus.sample_in_valid && buf_full && !frame_start;

            if (fall) begin
                bit_cnt <= bit_next;
                lrclk   <= lr_next;
                sdata   <= sdata_next;
            end

            if (frame_start) begin
                last_sample <= load_word;
            end

            if (bus.sample_in_valid) begin
                buf_data <= bus.sample_in;
                buf_full <= 1'b1;
            end else if (frame_start) begin
                buf_full <= 1'b0;
            end
        end
    end

    assign bus.sample_req = req;
    assign bus.i2s_bclk   = bclk;
    assign bus.i2s_lrclk  = lrclk;
    assign bus.i2s_sdata  = sdata;
    assign bus.underrun   = und;
    assign bus.overrun    = ovr;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: time-based frame model plus directed literal checks.
module tb_audio_i2s_tx;
    localparam int BH = 2;
    localparam int SW = 32;
    localparam int DW = 16;
`ifdef AUDIO_I2S_TX_MUTE_ON_UNDERRUN_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_i2s_tx_if #(.SAMPLE_WIDTH(DW)) bus ();

    audio_i2s_tx #(.SAMPLE_WIDTH(DW), .SLOT_WIDTH(SW), .BCLK_HALF(BH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int          t = 0;
    bit          active = 1'b0;
    bit          m_full;
    logic [15:0] m_buf, m_last, m_word;
    bit          e_req, e_und, e_ovr;
    logic [31:0] lvec [16];
    logic [31:0] rvec [16];
    bit          und_fr [16];
    int          req_q[$];
    int          und_q[$];
    int          ovr_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err < 40)
                $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
        end
    endtask

    // Model: outputs derived from elapsed time since reset and a transaction-level buffer.
    always @(posedge clk) begin
        bit          vin;
        logic [15:0] sin;
        bit          fs;
        int          k, bit_i, p, fr;
        bit          e_bclk, e_lr, e_sd;
        vin = bus.sample_in_valid;
        sin = bus.sample_in;
        if (rst) begin
            t = 0; active = 1'b1;
            m_full = 0; m_buf = 0; m_last = 0; m_word = 0;
            e_req = 0; e_und = 0; e_ovr = 0;
            req_q.delete(); und_q.delete(); ovr_q.delete();
        end else begin
            t++;
            fs = (t >= 2*BH) && (t % (2*BH) == 0) && (((t / (2*BH)) - 1) % (2*SW) == 0);
            e_req = fs;
            e_und = fs && !m_full;
            e_ovr = vin && m_full && !fs;
            if (fs) begin
                m_word = m_full ? m_buf : (MUTE ? 16'h0000 : m_last);
                m_last = m_word;
                m_full = 0;
            end
            if (vin) begin
                m_buf = sin;
                m_full = 1;
            end
        end
        #1;
        if (active) begin
            e_bclk = ((t / BH) % 2) == 1;
            e_lr = 0; e_sd = 0; k = 0; bit_i = 0;
            if (t >= 2*BH) begin
                k = t / (2*BH);
                bit_i = (k - 1) % (2*SW);
                e_lr = bit_i >= SW;
                p = bit_i % SW;
                e_sd = (p >= 1 && p <= DW) ? m_word[DW-p] : 1'b0;
            end
            chk("bclk", 32'(bus.i2s_bclk), 32'(e_bclk));
            chk("lrclk", 32'(bus.i2s_lrclk), 32'(e_lr));
            chk("sdata", 32'(bus.i2s_sdata), 32'(e_sd));
            chk("sample_req", 32'(bus.sample_req), 32'(e_req));
            chk("underrun", 32'(bus.underrun), 32'(e_und));
            chk("overrun", 32'(bus.overrun), 32'(e_ovr));
            if (bus.sample_req) req_q.push_back(t);
            if (bus.underrun) und_q.push_back(t);
            if (bus.overrun) ovr_q.push_back(t);
            if (t >= 2*BH && t % (2*BH) == 0) begin
                fr = (k - 1) / (2*SW);
                if (fr < 16) begin
                    if (bit_i < SW) lvec[fr][31-bit_i] = bus.i2s_sdata;
                    else rvec[fr][63-bit_i] = bus.i2s_sdata;
                    if (bit_i == 0) und_fr[fr] = bus.underrun;
                end
            end
        end
    end

    task automatic wait_t(int n);
        int b = 0;
        while (t != n && b < 20000) begin
            @(negedge clk);
            b++;
        end
        if (t != n) chk("wait_timeout", 32'(t), 32'(n));
    endtask

    // Drive a valid so that it is sampled on clock edge number e.
    task automatic send(int e, logic [15:0] v);
        wait_t(e - 1);
        bus.sample_in = v;
        bus.sample_in_valid = 1'b1;
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
    endtask

    initial begin
        bus.sample_in = '0;
        bus.sample_in_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {26'd0, bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata,
                              bus.sample_req, bus.underrun, bus.overrun}, 32'd0);
        rst = 1'b0;

        // 1: idle link timing
        wait_t(1);  chk("bclk_t1", 32'(bus.i2s_bclk), 32'd0);
        wait_t(2);  chk("bclk_t2", 32'(bus.i2s_bclk), 32'd1);
        wait_t(3);  chk("req_t3", 32'(bus.sample_req), 32'd0);
        wait_t(4);
        chk("req_t4", 32'(bus.sample_req), 32'd1);
        chk("und_t4", 32'(bus.underrun), 32'd1);
        chk("bclk_t4", 32'(bus.i2s_bclk), 32'd0);

        // 2: A5C3 into frame 1
        send(100, 16'hA5C3);
        wait_t(259); chk("req_t259", 32'(bus.sample_req), 32'd0);
        wait_t(260); chk("req_t260", 32'(bus.sample_req), 32'd1);

        // 3: 1234 into frame 2, frame 3 starved
        send(300, 16'h1234);
        wait_t(520);
        chk("f1_left", lvec[1], 32'h52E18000);
        chk("f1_right", rvec[1], 32'h52E18000);
        chk("f1_und", 32'(und_fr[1]), 32'd0);

        // 4: two valids in one frame
        send(800, 16'h1111);
        send(900, 16'h8000);
        wait_t(1030);
        chk("f2_left", lvec[2], 32'h091A0000);
        chk("f3_und", 32'(und_fr[3]), 32'd1);
        chk("f3_left", lvec[3], MUTE ? 32'h0 : 32'h091A0000);
        chk("f3_right", rvec[3], MUTE ? 32'h0 : 32'h091A0000);
        chk("ovr_count_a", 32'(ovr_q.size()), 32'd1);
        chk("ovr_time", 32'(ovr_q.size() > 0 ? ovr_q[0] : -1), 32'd900);

        // 5: valid coincident with frame-start load, buffer empty
        send(1284, 16'h7FFF);
        wait_t(1800);
        chk("f4_left", lvec[4], 32'h40000000);
        chk("f4_right", rvec[4], 32'h40000000);
        chk("f5_und", 32'(und_fr[5]), 32'd1);
        chk("f5_left", lvec[5], MUTE ? 32'h0 : 32'h40000000);
        chk("f6_left", lvec[6], 32'h3FFF8000);
        chk("f6_right", rvec[6], 32'h3FFF8000);
        chk("f6_und", 32'(und_fr[6]), 32'd0);
        chk("ovr_count_b", 32'(ovr_q.size()), 32'd1);

        // 6: reset mid-frame with a pending sample
        send(1900, 16'hBEEF);
        wait_t(1957);
        chk("lrclk_bit40", 32'(bus.i2s_lrclk), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {26'd0, bus.i2s_bclk, bus.i2s_lrclk, bus.i2s_sdata,
                                 bus.sample_req, bus.underrun, bus.overrun}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_t(300);
        chk("post_rst_req", 32'(req_q.size() > 0 ? req_q[0] : -1), 32'd4);
        chk("post_rst_und", 32'(und_q.size() > 0 ? und_q[0] : -1), 32'd4);
        chk("post_rst_f0_left", lvec[0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
